// File: rtl/board_pkg.sv
// rtl/board_pkg.sv - shared cell/state types and address helpers for the board memory
package board_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      SHIP  = 2'd1,
      HIT   = 2'd2,
      MISS  = 2'd3
   } cell_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_OP_RD = 2'd2,
      ST_OP_WR = 2'd3
   } state_t;

   localparam int DEF_X_ADDR_WIDTH = 4;
   localparam int DEF_Y_ADDR_WIDTH = 4;
   localparam int CELL_BITS        = 2;

   // x part of a packed {y,x} address
   function automatic int unsigned addr_lo(input int unsigned a, input int unsigned xw);
      return a & ((32'd1 << xw) - 32'd1);
   endfunction

   // y part of a packed {y,x} address
   function automatic int unsigned addr_hi(input int unsigned a, input int unsigned xw);
      return a >> xw;
   endfunction

   // cell code a shot leaves behind; HIT and MISS are sticky
   function automatic cell_t shot_next(input cell_t c);
      case (c)
         SHIP:    return HIT;
         EMPTY:   return MISS;
         default: return c;
      endcase
   endfunction

endpackage

// File: rtl/board_mem_clr_seq.sv
// rtl/board_mem_clr_seq.sv - x-inner / y-outer sweep counter for clearing a board
module board_mem_clr_seq #(
   parameter int X_SIZE = 16,
   parameter int Y_SIZE = 16,
   parameter int XW     = 4,
   parameter int YW     = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          run,
   output logic [XW-1:0] x,
   output logic [YW-1:0] y,
   output logic          done
);

   logic x_last;

   assign x_last = (32'(x) == 32'(X_SIZE - 1));
   assign done   = run && x_last && (32'(y) == 32'(Y_SIZE - 1));

   // advance one cell per running cycle, rewinding on start or after the last cell
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x <= '0;
         y <= '0;
      end else if (start || done) begin
         x <= '0;
         y <= '0;
      end else if (run) begin
         if (x_last) begin
            x <= '0;
            y <= y + 1'b1;
         end else begin
            x <= x + 1'b1;
         end
      end
   end

endmodule

// File: rtl/board_mem_ctrl.sv
// rtl/board_mem_ctrl.sv - single-clock board memory with clear sweep, atomic shot and ship count
module board_mem_ctrl
   import board_pkg::*;
#(
   parameter int X_SIZE       = 16,
   parameter int Y_SIZE       = 16,
   parameter int X_ADDR_WIDTH = DEF_X_ADDR_WIDTH,
   parameter int Y_ADDR_WIDTH = DEF_Y_ADDR_WIDTH,
   parameter int DATA_WIDTH   = 2,
   parameter int RD_PORTS     = 2,
   localparam int AW          = X_ADDR_WIDTH + Y_ADDR_WIDTH,
   localparam int CW          = $clog2(X_SIZE * Y_SIZE + 1)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         clr_req,
   output logic                         busy,
   input  logic                         wr_valid,
   output logic                         wr_ready,
   input  logic [AW-1:0]                wr_addr,
   input  logic [DATA_WIDTH-1:0]        wr_data,
   input  logic                         shot_valid,
   output logic                         shot_ready,
   input  logic [AW-1:0]                shot_addr,
   output logic                         shot_done,
   output logic [DATA_WIDTH-1:0]        shot_result,
   output logic                         shot_repeat,
   output logic                         shot_err,
   input  logic [RD_PORTS*AW-1:0]       rd_addr,
   output logic [RD_PORTS*DATA_WIDTH-1:0] rd_data,
   output logic [CW-1:0]                ships_left
);

   localparam int NCELL = X_SIZE * Y_SIZE;
   localparam int IW    = (NCELL > 1) ? $clog2(NCELL) : 1;

   function automatic logic in_range(input logic [AW-1:0] a);
      return (addr_lo(32'(a), X_ADDR_WIDTH) < X_SIZE) && (addr_hi(32'(a), X_ADDR_WIDTH) < Y_SIZE);
   endfunction

   function automatic logic [IW-1:0] cell_idx(input logic [AW-1:0] a);
      return IW'(addr_hi(32'(a), X_ADDR_WIDTH) * X_SIZE + addr_lo(32'(a), X_ADDR_WIDTH));
   endfunction

   state_t                  state;
   logic                    clr_pend;
   logic                    op_shot;
   logic [AW-1:0]           op_addr;
   logic [DATA_WIDTH-1:0]   op_data;
   cell_t                   op_old;
   logic                    op_ok;
   logic [IW-1:0]           op_idx;
   logic                    wr_is_ship;

   logic [X_ADDR_WIDTH-1:0] seq_x;
   logic [Y_ADDR_WIDTH-1:0] seq_y;
   logic                    seq_done;
   logic                    seq_start;
   logic                    seq_run;

   logic [DATA_WIDTH-1:0]   mem [NCELL];
   logic                    mem_we;
   logic [IW-1:0]           mem_idx;
   logic [DATA_WIDTH-1:0]   mem_wdata;

   assign op_ok      = in_range(op_addr);
   assign op_idx     = cell_idx(op_addr);
   assign wr_is_ship = (op_data == DATA_WIDTH'(SHIP));
   assign seq_start  = (state == ST_IDLE) && (clr_req || clr_pend);
   assign seq_run    = (state == ST_CLEAR);

   board_mem_clr_seq #(
      .X_SIZE (X_SIZE),
      .Y_SIZE (Y_SIZE),
      .XW     (X_ADDR_WIDTH),
      .YW     (Y_ADDR_WIDTH)
   ) u_clr_seq (
      .clk   (clk),
      .rst_n (rst_n),
      .start (seq_start),
      .run   (seq_run),
      .x     (seq_x),
      .y     (seq_y),
      .done  (seq_done)
   );

   // single array write port: sweep cell while clearing, else the RMW write-back
   always_comb begin
      mem_we    = 1'b0;
      mem_idx   = op_idx;
      mem_wdata = op_shot ? DATA_WIDTH'(shot_next(op_old)) : op_data;
      if (state == ST_CLEAR) begin
         mem_we    = 1'b1;
         mem_idx   = cell_idx({seq_y, seq_x});
         mem_wdata = '0;
      end else if (state == ST_OP_WR && op_ok) begin
         mem_we = 1'b1;
      end
   end

   // cell storage, deliberately not reset (the clear sweep initialises it)
   always_ff @(posedge clk) begin
      if (mem_we)
         mem[mem_idx] <= mem_wdata;
   end

   // registered read ports; a same-edge write returns the old cell value
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data <= '0;
      end else begin
         for (int i = 0; i < RD_PORTS; i++)
            rd_data[i*DATA_WIDTH +: DATA_WIDTH] <= in_range(rd_addr[i*AW +: AW]) ?
                                                   mem[cell_idx(rd_addr[i*AW +: AW])] : '0;
      end
   end

   // control FSM: clear sweep, read-modify-write for shots and writes, ship counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_CLEAR;
         busy        <= 1'b1;
         wr_ready    <= 1'b0;
         shot_ready  <= 1'b0;
         shot_done   <= 1'b0;
         shot_result <= '0;
         shot_repeat <= 1'b0;
         shot_err    <= 1'b0;
         ships_left  <= '0;
         clr_pend    <= 1'b0;
         op_shot     <= 1'b0;
         op_addr     <= '0;
         op_data     <= '0;
         op_old      <= EMPTY;
      end else begin
         shot_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (clr_req || clr_pend) begin
                  state      <= ST_CLEAR;
                  busy       <= 1'b1;
                  wr_ready   <= 1'b0;
                  shot_ready <= 1'b0;
                  clr_pend   <= 1'b0;
                  ships_left <= '0;
               end else if (shot_valid && shot_ready) begin
                  state      <= ST_OP_RD;
                  wr_ready   <= 1'b0;
                  shot_ready <= 1'b0;
                  op_shot    <= 1'b1;
                  op_addr    <= shot_addr;
               end else if (wr_valid && wr_ready) begin
                  state      <= ST_OP_RD;
                  wr_ready   <= 1'b0;
                  shot_ready <= 1'b0;
                  op_shot    <= 1'b0;
                  op_addr    <= wr_addr;
                  op_data    <= wr_data;
               end
            end
            ST_CLEAR: begin
               if (seq_done) begin
                  state      <= ST_IDLE;
                  busy       <= 1'b0;
                  wr_ready   <= 1'b1;
                  shot_ready <= 1'b1;
               end
            end
            ST_OP_RD: begin
               state    <= ST_OP_WR;
               clr_pend <= clr_pend | clr_req;
               op_old   <= op_ok ? cell_t'(mem[op_idx][CELL_BITS-1:0]) : EMPTY;
            end
            ST_OP_WR: begin
               state      <= ST_IDLE;
               clr_pend   <= clr_pend | clr_req;
               wr_ready   <= !(clr_pend || clr_req);
               shot_ready <= !(clr_pend || clr_req);
               if (op_shot) begin
                  shot_done   <= 1'b1;
                  shot_err    <= !op_ok;
                  shot_result <= op_ok ? DATA_WIDTH'(shot_next(op_old)) : '0;
                  shot_repeat <= op_ok && (op_old == HIT || op_old == MISS);
                  if (op_ok && op_old == SHIP)
                     ships_left <= ships_left - CW'(1);
               end else if (op_ok) begin
                  if (op_old != SHIP && wr_is_ship)
                     ships_left <= ships_left + CW'(1);
                  else if (op_old == SHIP && !wr_is_ship)
                     ships_left <= ships_left - CW'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
